// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: writeback requesters and register-file write port
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic                      wb_stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      regWrite;
  logic [ADDR_W-1:0]         writeReg;
  logic [DATA_W-1:0]         writeData;
  logic                      wb_busy;
  modport master (
    output wb_stall, req_valid, req_addr, req_data,
    input  req_ready, regWrite, writeReg, writeData, wb_busy
  );
  modport slave (
    input  wb_stall, req_valid, req_addr, req_data,
    output req_ready, regWrite, writeReg, writeData, wb_busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of the register-file write port
module reg_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] upper, cand, gnt;
  logic [ADDR_W-1:0]  sel_addr, write_reg_q;
  logic [DATA_W-1:0]  sel_data, write_data_q;
  logic               xfer, reg_write_q;
  // Pick the lowest valid index at or above ptr, else wrap to the lowest valid overall.
  always_comb begin
    upper    = bus.req_valid & ~((ONE << ptr_q) - ONE);
    cand     = (|upper) ? upper : bus.req_valid;
    gnt      = (bus.wb_stall || !rst_n) ? '0 : cand & (~cand + ONE);
    xfer     = |gnt;
    sel_addr = '0;
    sel_data = '0;
    ptr_d    = ptr_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
        ptr_d    = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
      end
  end
  // Register the winning write; r0 targets load address/data but never enable the write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= xfer && (sel_addr != '0);
      write_reg_q  <= xfer ? sel_addr : write_reg_q;
      write_data_q <= xfer ? sel_data : write_data_q;
    end
  assign bus.req_ready = gnt;
  assign bus.wb_busy   = |(bus.req_valid & ~gnt);
  assign bus.regWrite  = reg_write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;
endmodule
